// File: rtl/pfs_bus_client.sv
// rtl/pfs_bus_client.sv - PFS register bus requester: command FIFO, req/gnt sequencer, read response port
module pfs_bus_client #(
  parameter int AW    = 12,
  parameter int ROW_W = 2,
  parameter int DW    = 16,
  parameter int ROWS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 soft_reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [DW-1:0]        cmd_wdata,
  output logic                 wr_req,
  input  logic                 wr_gnt,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic                 rd_req,
  input  logic                 rd_gnt,
  output logic [AW-ROW_W-1:0]  rd_addr,
  input  logic [ROWS*DW-1:0]   rd_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DW-1:0]        resp_data,
  output logic                 busy
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int CW = 1 + AW + DW;

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     fifo_mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic              full, empty, push, pop;
  logic              head_write;
  logic [AW-1:0]     head_addr;
  logic [DW-1:0]     head_data;
  logic [AW-1:0]     held_addr;
  logic [DW-1:0]     held_data;
  logic [DW-1:0]     resp_q;
  logic [DW-1:0]     row_word;
  logic [ROW_W-1:0]  row;

  // Extra pointer MSB separates full from empty when the indices coincide.
  assign full      = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign empty     = (wptr == rptr);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !soft_reset;

  assign {head_write, head_addr, head_data} = fifo_mem[rptr[PW-2:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (soft_reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr[PW-2:0]] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = head_write ? WR : RD;
        end
      end
      WR: begin
        wr_req = 1'b1;
        if (wr_gnt) state_nxt = IDLE;
      end
      RD: begin
        rd_req = 1'b1;
        if (rd_gnt) state_nxt = RD_WAIT;
      end
      RD_WAIT: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A grant arriving with the flush still commits at the master; the client just forgets it.
    if (soft_reset) begin
      state_nxt = IDLE;
      pop       = 1'b0;
    end
  end

  assign row = held_addr[AW-1 -: ROW_W];

  always_comb begin
    row_word = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row == r[ROW_W-1:0]) row_word = rd_data[r*DW +: DW];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held_addr <= '0;
      held_data <= '0;
      resp_q    <= '0;
    end else begin
      if (pop) begin
        held_addr <= head_addr;
        held_data <= head_data;
      end
      if (state == RD_WAIT) resp_q <= row_word;
    end
  end

  assign wr_addr   = held_addr;
  assign wr_data   = held_data;
  assign rd_addr   = held_addr[AW-ROW_W-1:0];
  assign resp_data = resp_q;
  assign busy      = !empty || (state != IDLE);

endmodule

// File: tb/tb_pfs_bus_client.sv
// tb/tb_pfs_bus_client.sv - directed bench for pfs_bus_client with a register-bank master model
module tb_pfs_bus_client;

  localparam int AW = 12, ROW_W = 2, DW = 16, ROWS = 4, DEPTH = 4;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 soft_reset = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic                 cmd_write = 1'b0;
  logic [AW-1:0]        cmd_addr = '0;
  logic [DW-1:0]        cmd_wdata = '0;
  logic                 wr_req, wr_gnt;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic                 rd_req, rd_gnt;
  logic [AW-ROW_W-1:0]  rd_addr;
  logic [ROWS*DW-1:0]   rd_data = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [DW-1:0]        resp_data;
  logic                 busy;

  logic                 gnt_en = 1'b0;
  logic [DW-1:0]        bank [0:(1<<AW)-1];
  logic [AW-1:0]        commit_addr [$];
  int                   n_commit = 0;
  int                   n_cmp = 0;
  int                   n_mis = 0;

  pfs_bus_client #(.AW(AW), .ROW_W(ROW_W), .DW(DW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .soft_reset(soft_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  assign wr_gnt = gnt_en & wr_req;
  assign rd_gnt = gnt_en & rd_req;

  always @(posedge clock) begin
    if (wr_req && wr_gnt) begin
      bank[wr_addr] <= wr_data;
      commit_addr.push_back(wr_addr);
      n_commit <= n_commit + 1;
    end
    if (rd_req && rd_gnt) begin
      for (int r = 0; r < ROWS; r++) rd_data[r*DW +: DW] <= bank[{r[ROW_W-1:0], rd_addr}];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    for (int k = 0; k < 30 && !resp_valid; k++) tick();
    chk(tag, resp_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 60 && busy; k++) tick();
    chk(tag, busy, 0);
  endtask

  initial begin
    int cb;
    int qb;
    logic found;
    for (int i = 0; i < (1<<AW); i++) bank[i] = DW'(i) + 16'h1000;

    // reset state
    #12;
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_resp_data", resp_data, 0);

    // write then read back, immediate grants
    gnt_en = 1'b1;
    push(1'b1, 12'h2A5, 16'h1234);
    chk("t1_busy", busy, 1);
    chk("t1_wr_req_early", wr_req, 0);
    tick();
    chk("t1_wr_req", wr_req, 1);
    chk("t1_wr_addr", wr_addr, 12'h2A5);
    chk("t1_wr_data", wr_data, 16'h1234);
    chk("t1_no_commit_yet", n_commit, 0);
    tick();
    chk("t1_commit", n_commit, 1);
    chk("t1_wr_req_drop", wr_req, 0);
    push(1'b0, 12'h2A5, 16'h0000);
    chk("t1_rd_req_early", rd_req, 0);
    tick();
    chk("t1_rd_req", rd_req, 1);
    chk("t1_rd_addr", rd_addr, 10'h2A5);
    tick();
    chk("t1_resp_not_yet", resp_valid, 0);
    tick();
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_data", resp_data, 16'h1234);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("t1_resp_drop", resp_valid, 0);

    // row 3 selection: row 0 of the same column holds 0x1234
    push(1'b0, 12'hEA5, 16'h0000);
    wait_resp("t1_row3_valid");
    chk("t1_row3_data", resp_data, 16'h1EA5);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // FIFO fill while the FSM is stuck in an ungranted write
    gnt_en = 1'b0;
    qb = commit_addr.size();
    cb = n_commit;
    push(1'b1, 12'h100, 16'hAAAA);
    tick();
    chk("t2_c0_wr_req", wr_req, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_ready_before_push", cmd_ready, 1);
      push(1'b1, 12'(32'h101 + i), 16'(i + 1));
    end
    chk("t2_full", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h105;
    cmd_wdata = 16'h0005;
    tick();
    tick();
    chk("t2_still_full", cmd_ready, 0);
    chk("t2_no_commit", n_commit, cb);
    gnt_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (cmd_ready) begin
        chk("t2_commits_at_accept", n_commit, cb + 1);
        tick();
        found = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("t2_fifth_accepted", found, 1);
    wait_idle("t2_drain");
    chk("t2_commit_count", commit_addr.size(), qb + 6);
    for (int j = 0; j < 6; j++) chk("t2_order", commit_addr[qb + j], 32'h100 + j);

    // write grant withheld for 6 cycles
    gnt_en = 1'b0;
    push(1'b1, 12'h3C7, 16'hBEEF);
    tick();
    cb = n_commit;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) gnt_en = 1'b1;
      chk("t3_wr_req", wr_req, 1);
      chk("t3_wr_addr", wr_addr, 12'h3C7);
      chk("t3_wr_data", wr_data, 16'hBEEF);
      tick();
    end
    chk("t3_wr_req_drop", wr_req, 0);
    chk("t3_one_commit", n_commit, cb + 1);
    tick();
    chk("t3_still_one_commit", n_commit, cb + 1);

    // response back-pressure holds data and blocks the next pop
    resp_ready = 1'b0;
    push(1'b0, 12'h2A5, 16'h0000);
    push(1'b1, 12'h055, 16'h7777);
    wait_resp("t4_resp_valid");
    cb = n_commit;
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_valid", resp_valid, 1);
      chk("t4_hold_data", resp_data, 16'h1234);
      chk("t4_no_pop", wr_req, 0);
      tick();
    end
    chk("t4_no_commit", n_commit, cb);
    chk("t4_busy", busy, 1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("t4_resp_drop", resp_valid, 0);
    chk("t4_idle_gap", wr_req, 0);
    tick();
    chk("t4_next_wr_req", wr_req, 1);
    chk("t4_next_wr_addr", wr_addr, 12'h055);
    tick();
    chk("t4_next_commit", n_commit, cb + 1);

    // soft reset in RD with two commands queued and a concurrent push
    gnt_en = 1'b0;
    resp_ready = 1'b1;
    push(1'b0, 12'hEA5, 16'h0000);
    push(1'b1, 12'h200, 16'h0001);
    push(1'b1, 12'h201, 16'h0002);
    chk("t5_rd_req", rd_req, 1);
    chk("t5_rd_addr", rd_addr, 10'h2A5);
    cb = n_commit;
    soft_reset = 1'b1;
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 12'h202;
    tick();
    soft_reset = 1'b0;
    cmd_valid  = 1'b0;
    chk("t5_rd_req_drop", rd_req, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    chk("t5_resp_valid", resp_valid, 0);
    gnt_en = 1'b1;
    repeat (5) tick();
    chk("t5_no_wr_req", wr_req, 0);
    chk("t5_no_resp", resp_valid, 0);
    chk("t5_no_commit", n_commit, cb);
    chk("t5_still_idle", busy, 0);

    // asynchronous reset mid-write
    gnt_en = 1'b0;
    resp_ready = 1'b0;
    push(1'b1, 12'h0F0, 16'h5555);
    tick();
    chk("t6_wr_req", wr_req, 1);
    cb = n_commit;
    #3 reset_n = 1'b0;
    #1;
    chk("t6_wr_req_async_drop", wr_req, 0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    #1;
    chk("t6_wr_addr", wr_addr, 0);
    chk("t6_wr_data", wr_data, 0);
    chk("t6_rd_req", rd_req, 0);
    chk("t6_rd_addr", rd_addr, 0);
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_resp_data", resp_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    gnt_en = 1'b1;
    repeat (3) tick();
    chk("t6_lost_cmd", n_commit, cb);
    chk("t6_wr_req_idle", wr_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
